// File: rtl/img_template_lut.sv
// Template lookup: maps screen coordinates relative to a window origin onto a tiled RAM.
// Optional per-query horizontal mirroring is enabled by defining IMG_TEMPLATE_MIRROR_EN.
module img_template_lut #(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned COORD_W  = 13,
    parameter int unsigned TW_LOG2  = 4,
    parameter int unsigned TH_LOG2  = 4,
    parameter int unsigned SHIFT    = 4,
    parameter int unsigned INIT_VAL = 0,
    parameter int unsigned OOB_VAL  = 1020
) (
    input  logic                       iCLK,
    input  logic                       iRST_N,
    input  logic [COORD_W-1:0]         iX,
    input  logic [COORD_W-1:0]         iY,
    input  logic                       iREQ,
    input  logic [COORD_W-1:0]         iORG_X,
    input  logic [COORD_W-1:0]         iORG_Y,
`ifdef IMG_TEMPLATE_MIRROR_EN
    input  logic                       iMIRROR,
`endif
    input  logic                       iWR_EN,
    input  logic [TW_LOG2+TH_LOG2-1:0] iWR_ADDR,
    input  logic [DATA_W-1:0]          iWR_DATA,
    output logic                       oREADY,
    output logic [DATA_W-1:0]          oPIX,
    output logic                       oPIX_VLD,
    output logic                       oHIT
);

    localparam int unsigned AW     = TW_LOG2 + TH_LOG2;
    localparam int unsigned DEPTH  = 1 << AW;
    localparam int unsigned X_SPAN = 1 << (TW_LOG2 + SHIFT);
    localparam int unsigned Y_SPAN = 1 << (TH_LOG2 + SHIFT);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q;
    logic [AW-1:0]       init_addr_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                vld1_q, vld2_q, vld3_q;
    logic                hit1_q, hit2_q, hit3_q;
    logic [DATA_W-1:0]   rd1_q, pix2_q, pix3_q;

    logic [COORD_W:0]    dx_c, dy_c;
    logic                hit_c, req_c, mirror_c;
    logic [TW_LOG2-1:0]  col_c;
    logic [TH_LOG2-1:0]  row_c;
    logic [AW-1:0]       rd_addr_c;
    logic                we_c;
    logic [AW-1:0]       wa_c;
    logic [DATA_W-1:0]   wd_c;

`ifdef IMG_TEMPLATE_MIRROR_EN
    assign mirror_c = iMIRROR;
`else
    assign mirror_c = 1'b0;
`endif

    // Zero-extended subtraction yields the exact signed offset in COORD_W+1 bits.
    assign dx_c  = {1'b0, iX} - {1'b0, iORG_X};
    assign dy_c  = {1'b0, iY} - {1'b0, iORG_Y};
    assign hit_c = !dx_c[COORD_W] && (dx_c < (COORD_W+1)'(X_SPAN)) &&
                   !dy_c[COORD_W] && (dy_c < (COORD_W+1)'(Y_SPAN));
    assign col_c = dx_c[SHIFT +: TW_LOG2] ^ {TW_LOG2{mirror_c}};
    assign row_c = dy_c[SHIFT +: TH_LOG2];
    assign rd_addr_c = {row_c, col_c};
    assign req_c = iREQ && (state_q == ST_RUN);

    // Single write port: init sweep owns it until the FSM reaches RUN.
    always_comb begin
        we_c = 1'b0;
        wa_c = iWR_ADDR;
        wd_c = iWR_DATA;
        if (state_q == ST_INIT) begin
            we_c = 1'b1;
            wa_c = init_addr_q;
            wd_c = DATA_W'(INIT_VAL);
        end else if (iWR_EN) begin
            we_c = 1'b1;
        end
    end

    // Read and write share the edge, so a colliding read sees the old word.
    always_ff @(posedge iCLK) begin
        if (we_c) begin
            mem_q[wa_c] <= wd_c;
        end
        rd1_q <= mem_q[rd_addr_c];
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            oREADY      <= 1'b0;
            vld1_q      <= 1'b0;
            hit1_q      <= 1'b0;
            vld2_q      <= 1'b0;
            hit2_q      <= 1'b0;
            pix2_q      <= '0;
            vld3_q      <= 1'b0;
            hit3_q      <= 1'b0;
            pix3_q      <= '0;
            oPIX_VLD    <= 1'b0;
            oHIT        <= 1'b0;
            oPIX        <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_addr_q <= init_addr_q + AW'(1);
                    if (init_addr_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        oREADY  <= 1'b1;
                    end
                end
                default: begin
                    oREADY <= 1'b1;
                end
            endcase

            vld1_q <= req_c;
            hit1_q <= hit_c;

            vld2_q <= vld1_q;
            hit2_q <= hit1_q;
            pix2_q <= hit1_q ? rd1_q : DATA_W'(OOB_VAL);

            vld3_q <= vld2_q;
            hit3_q <= hit2_q;
            pix3_q <= pix2_q;

            // Result registers hold their last value between strobes.
            oPIX_VLD <= vld3_q;
            if (vld3_q) begin
                oPIX <= pix3_q;
                oHIT <= hit3_q;
            end
        end
    end

endmodule

// File: tb/tb_img_template_lut.sv
// Randomized self-checking bench for img_template_lut against a coordinate-level reference model.
module tb_img_template_lut;

    localparam int unsigned DATA_W  = 10;
    localparam int unsigned COORD_W = 13;
    localparam int unsigned AW      = 8;
    localparam int unsigned DEPTH   = 256;
    localparam int          OOB     = 1020;

    logic                iCLK = 1'b0;
    logic                iRST_N;
    logic [COORD_W-1:0]  iX, iY, iORG_X, iORG_Y;
    logic                iREQ, iWR_EN;
    logic [AW-1:0]       iWR_ADDR;
    logic [DATA_W-1:0]   iWR_DATA;
    logic                mirror_s;
    logic                oREADY, oPIX_VLD, oHIT;
    logic [DATA_W-1:0]   oPIX;

    int total = 0;
    int bad   = 0;
    int model_mem [DEPTH];

    typedef struct {
        int due;
        int pix;
        bit hit;
    } exp_t;

    img_template_lut dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iX       (iX),
        .iY       (iY),
        .iREQ     (iREQ),
        .iORG_X   (iORG_X),
        .iORG_Y   (iORG_Y),
`ifdef IMG_TEMPLATE_MIRROR_EN
        .iMIRROR  (mirror_s),
`endif
        .iWR_EN   (iWR_EN),
        .iWR_ADDR (iWR_ADDR),
        .iWR_DATA (iWR_DATA),
        .oREADY   (oREADY),
        .oPIX     (oPIX),
        .oPIX_VLD (oPIX_VLD),
        .oHIT     (oHIT)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic idle();
        iREQ = 1'b0; iWR_EN = 1'b0; iWR_ADDR = '0; iWR_DATA = '0;
        iX = '0; iY = '0; iORG_X = '0; iORG_Y = '0; mirror_s = 1'b0;
    endtask

    task automatic drive_query(input int x, input int y, input int ox, input int oy);
        iREQ = 1'b1; iX = COORD_W'(x); iY = COORD_W'(y);
        iORG_X = COORD_W'(ox); iORG_Y = COORD_W'(oy);
    endtask

    task automatic drive_write(input int a, input int d);
        iWR_EN = 1'b1; iWR_ADDR = AW'(a); iWR_DATA = DATA_W'(d);
        model_mem[a] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 0;
    endtask

    // Window is 256x256 pixels of 16x16 tiles; addresses are row*16+col.
    function automatic void ref_lookup(input int x, input int y, input int ox, input int oy,
                                       input bit mir, output int pix, output bit hit);
        int dx, dy, col, row;
        dx  = x - ox;
        dy  = y - oy;
        hit = (dx >= 0) && (dx < 256) && (dy >= 0) && (dy < 256);
        pix = OOB;
        if (hit) begin
            col = dx / 16;
            row = dy / 16;
            if (mir) col = 15 - col;
            pix = model_mem[row * 16 + col];
        end
    endfunction

    task automatic test_reset();
        int ep; bit eh;
        idle();
        iRST_N = 1'b1;
        #1 iRST_N = 1'b0;
        tick(); tick();
        total++;
        if (oREADY !== 1'b0 || oPIX_VLD !== 1'b0 || oPIX !== '0 || oHIT !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: ready=%0b vld=%0b pix=%0d hit=%0b, want 0 0 0 0",
                     oREADY, oPIX_VLD, oPIX, oHIT);
        end
        iRST_N = 1'b1;
        model_clear();
        // Requests and writes during the sweep must be ignored.
        drive_query(48, 48, 0, 0);
        iWR_EN = 1'b1; iWR_ADDR = 8'h33; iWR_DATA = 10'd999;
        for (int i = 1; i <= 255; i++) begin
            tick();
            total++;
            if (oREADY !== 1'b0 || oPIX_VLD !== 1'b0) begin
                bad++;
                $display("FAIL init_busy[%0d]: ready=%0b vld=%0b, want 0 0", i, oREADY, oPIX_VLD);
            end
        end
        idle();
        tick();
        total++;
        if (oREADY !== 1'b1) begin
            bad++;
            $display("FAIL init_done: ready=%0b, want 1 after 256 cycles", oREADY);
        end
        ref_lookup(0, 0, 0, 0, 1'b0, ep, eh);
        drive_query(0, 0, 0, 0);
        tick();
        idle();
        tick(); tick(); tick();
        total++;
        if (oPIX_VLD !== 1'b1 || oPIX !== DATA_W'(ep) || oHIT !== eh) begin
            bad++;
            $display("FAIL first_query: vld=%0b pix=%0d hit=%0b, want 1 %0d %0b", oPIX_VLD, oPIX, oHIT, ep, eh);
        end
    endtask

    task automatic test_lookup();
        int qx[10] = '{160, 99, 356, 100, 48, 355, 100, 0, 8191, 355};
        int qy[10] = '{80, 60, 60, 50, 48, 305, 306, 0, 0, 306};
        int ox[10] = '{0, 100, 100, 100, 0, 100, 100, 8191, 0, 100};
        int oy[10] = '{0, 50, 50, 50, 0, 50, 50, 0, 0, 50};
        int ep, held; bit eh;
        idle();
        drive_write(8'h5A, 428); tick(); idle();
        drive_write(8'h00, 321); tick(); idle();
        drive_write(8'hFF, 77);  tick(); idle();
        for (int i = 0; i < 10; i++) begin
            ref_lookup(qx[i], qy[i], ox[i], oy[i], 1'b0, ep, eh);
            drive_query(qx[i], qy[i], ox[i], oy[i]);
            tick();
            idle();
            for (int k = 1; k <= 4; k++) begin
                tick();
                total++;
                if (k < 3 && oPIX_VLD !== 1'b0) begin
                    bad++;
                    $display("FAIL lookup_early[%0d]: vld=%0b at cycle %0d, want 0", i, oPIX_VLD, k);
                end else if (k == 3 && (oPIX_VLD !== 1'b1 || oPIX !== DATA_W'(ep) || oHIT !== eh)) begin
                    bad++;
                    $display("FAIL lookup[%0d]: vld=%0b pix=%0d hit=%0b, want 1 %0d %0b",
                             i, oPIX_VLD, oPIX, oHIT, ep, eh);
                end else if (k == 4 && (oPIX_VLD !== 1'b0 || oPIX !== DATA_W'(ep) || oHIT !== eh)) begin
                    bad++;
                    $display("FAIL lookup_hold[%0d]: vld=%0b pix=%0d hit=%0b, want 0 %0d %0b",
                             i, oPIX_VLD, oPIX, oHIT, ep, eh);
                end
            end
            held = ep;
        end
    endtask

    task automatic test_back_to_back();
        int ep[8]; bit eh[8];
        int org_x, org_y, a, x, y;
        org_x = int'($urandom_range(0, 4000));
        org_y = int'($urandom_range(0, 4000));
        for (int t = 0; t < 13; t++) begin
            idle();
            if (t < 8) begin
                a = int'($urandom_range(0, 255));
                x = org_x + (a % 16) * 16 + int'($urandom_range(0, 15));
                y = org_y + (a / 16) * 16 + int'($urandom_range(0, 15));
                ref_lookup(x, y, org_x, org_y, 1'b0, ep[t], eh[t]);
                drive_query(x, y, org_x, org_y);
                drive_write(a, int'($urandom_range(0, 1023)));
            end
            tick();
            total++;
            if (t >= 3 && t < 11) begin
                if (oPIX_VLD !== 1'b1 || oPIX !== DATA_W'(ep[t-3]) || oHIT !== eh[t-3]) begin
                    bad++;
                    $display("FAIL b2b[%0d]: vld=%0b pix=%0d hit=%0b, want 1 %0d %0b",
                             t - 3, oPIX_VLD, oPIX, oHIT, ep[t-3], eh[t-3]);
                end
            end else if (oPIX_VLD !== 1'b0) begin
                bad++;
                $display("FAIL b2b_idle[%0d]: vld=%0b, want 0", t, oPIX_VLD);
            end
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int x, y, ox, oy, ep, last_pix;
        bit eh, mir, have_last, last_hit;
        have_last = 1'b0; last_pix = 0; last_hit = 1'b0;
        for (int t = 0; t < 304; t++) begin
            idle();
            if (t < 300) begin
                if ($urandom_range(0, 1) == 1) begin
                    ox = int'($urandom_range(0, 8191));
                    oy = int'($urandom_range(0, 8191));
                    x = (ox + int'($urandom_range(0, 320)) - 32) & 8191;
                    y = (oy + int'($urandom_range(0, 320)) - 32) & 8191;
                    mir = 1'b0;
`ifdef IMG_TEMPLATE_MIRROR_EN
                    mir = 1'($urandom_range(0, 1));
`endif
                    ref_lookup(x, y, ox, oy, mir, ep, eh);
                    q.push_back('{t + 3, ep, eh});
                    drive_query(x, y, ox, oy);
                    mirror_s = mir;
                end
                if ($urandom_range(0, 1) == 1)
                    drive_write(int'($urandom_range(0, 255)), int'($urandom_range(0, 1023)));
            end
            tick();
            total++;
            if (q.size() > 0 && q[0].due == t) begin
                e = q.pop_front();
                if (oPIX_VLD !== 1'b1 || oPIX !== DATA_W'(e.pix) || oHIT !== e.hit) begin
                    bad++;
                    $display("FAIL random[%0d]: vld=%0b pix=%0d hit=%0b, want 1 %0d %0b",
                             t, oPIX_VLD, oPIX, oHIT, e.pix, e.hit);
                end
                have_last = 1'b1; last_pix = e.pix; last_hit = e.hit;
            end else if (oPIX_VLD !== 1'b0 ||
                         (have_last && (oPIX !== DATA_W'(last_pix) || oHIT !== last_hit))) begin
                bad++;
                $display("FAIL random_idle[%0d]: vld=%0b pix=%0d hit=%0b, want 0 %0d %0b",
                         t, oPIX_VLD, oPIX, oHIT, last_pix, last_hit);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int ep; bit eh;
        idle();
        drive_write(8'h5A, 500); tick(); idle();
        drive_query(160, 80, 0, 0); tick();
        drive_query(160, 80, 0, 0); tick();
        idle();
        iRST_N = 1'b0;
        #1;
        total++;
        if (oPIX_VLD !== 1'b0 || oREADY !== 1'b0 || oPIX !== '0 || oHIT !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state: vld=%0b ready=%0b pix=%0d hit=%0b, want 0 0 0 0",
                     oPIX_VLD, oREADY, oPIX, oHIT);
        end
        tick();
        iRST_N = 1'b1;
        model_clear();
        for (int i = 1; i <= 256; i++) begin
            tick();
            total++;
            if (oPIX_VLD !== 1'b0 || oREADY !== (i == 256)) begin
                bad++;
                $display("FAIL midreset_sweep[%0d]: vld=%0b ready=%0b, want 0 %0b",
                         i, oPIX_VLD, oREADY, i == 256);
            end
        end
        ref_lookup(160, 80, 0, 0, 1'b0, ep, eh);
        drive_query(160, 80, 0, 0);
        tick();
        idle();
        tick(); tick(); tick();
        total++;
        if (oPIX_VLD !== 1'b1 || oPIX !== DATA_W'(ep) || oHIT !== eh) begin
            bad++;
            $display("FAIL midreset_reinit: vld=%0b pix=%0d hit=%0b, want 1 %0d %0b", oPIX_VLD, oPIX, oHIT, ep, eh);
        end
    endtask

`ifdef IMG_TEMPLATE_MIRROR_EN
    task automatic test_mirror();
        int ep; bit eh;
        idle();
        drive_write(8'h0F, 7); tick(); idle();
        ref_lookup(0, 0, 0, 0, 1'b1, ep, eh);
        drive_query(0, 0, 0, 0);
        mirror_s = 1'b1;
        tick();
        idle();
        tick(); tick(); tick();
        total++;
        if (oPIX_VLD !== 1'b1 || oPIX !== DATA_W'(ep) || oHIT !== eh) begin
            bad++;
            $display("FAIL mirror: vld=%0b pix=%0d hit=%0b, want 1 %0d %0b", oPIX_VLD, oPIX, oHIT, ep, eh);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lookup();
        test_back_to_back();
        test_random();
        test_reset_midflight();
`ifdef IMG_TEMPLATE_MIRROR_EN
        test_mirror();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
